// File: rtl/fault_sim_ctrl.sv
// Fault-simulation controller: walks a fault injection list, applies an
// LFSR pattern set per fault and counts faults evaluated and detected.
module fault_sim_ctrl #(
  parameter int unsigned IN_BITS  = 60,
  parameter int unsigned OUT_BITS = 26,
  parameter int unsigned PAT_CNT  = 256,
  parameter int unsigned CNT_W    = 16,
  parameter logic [IN_BITS-1:0] SEED = {{(IN_BITS-1){1'b0}}, 1'b1},
  parameter logic [IN_BITS-1:0] POLY = 60'h800000000000003
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                FIL_RST,
  output logic                FIL_INC,
  input  logic                FIL_END,
  output logic [IN_BITS-1:0]  TEST_IP,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    fault_cnt,
  output logic [CNT_W-1:0]    detect_cnt
);

  localparam int unsigned PC_W = (PAT_CNT > 1) ? $clog2(PAT_CNT) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_INC,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IN_BITS-1:0] lfsr_q, lfsr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               frst_q, finc_q;
  logic [IN_BITS-1:0] step;
  logic               mism;

  assign step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
  assign mism = (CUT_OP != FF_OP);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        lfsr_d  = SEED;
        pc_d    = '0;
        fcnt_d  = '0;
        dcnt_d  = '0;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        // a detected fault is dropped at once
        if (mism) begin
          if (dcnt_q != CNT_MAX) dcnt_d = dcnt_q + 1'b1;
          state_d = S_INC;
        end else if (pc_q == PC_LAST) begin
          state_d = S_INC;
        end else begin
          lfsr_d = step;
          pc_d   = pc_q + 1'b1;
        end
      end
      S_INC: begin
        if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + 1'b1;
        lfsr_d  = SEED;
        pc_d    = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = FIL_END ? S_DONE : S_APPLY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      pc_q    <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      frst_q  <= 1'b0;
      finc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      frst_q  <= (state_d == S_LOAD);
      finc_q  <= (state_d == S_INC);
    end
  end

  assign FIL_RST    = frst_q;
  assign FIL_INC    = finc_q;
  assign TEST_IP    = lfsr_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign fault_cnt  = fcnt_q;
  assign detect_cnt = dcnt_q;

endmodule
